// File: rtl/mux_share_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// Build option: MUX_ARB_STATS_EN adds grant counters and a forced-switch pulse.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/mux_share_arbiter_hold_counter.sv
// Saturating hold counter: counts contested ownership cycles and flags the last
// cycle an owner may keep the path while the other requester waits.
module arb_hold_counter #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic term
);

    localparam logic [HOLD_W-1:0] TERM_VAL = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] cnt;

    assign term = (cnt == TERM_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !term) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 4-bit 2:1 datapath with a registered output word.
// Build option: MUX_ARB_STATS_EN adds grant_cnt_a/grant_cnt_b and forced_sw.
module mux_share_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       sel,
    output logic       en,
    output logic [3:0] out_data,
    output logic       out_valid
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [7:0] grant_cnt_a,
    output logic [7:0] grant_cnt_b,
    output logic       forced_sw
`endif
);

    arb_state_e state;
    arb_state_e next_state;
    logic       last_b;
    logic       hold_clr;
    logic       hold_inc;
    logic       hold_term;
    logic       forced;

    arb_hold_counter #(
        .HOLD_W  (HOLD_W),
        .MAX_HOLD(MAX_HOLD)
    ) u_hold (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (hold_clr),
        .inc  (hold_inc),
        .term (hold_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        forced     = 1'b0;
        hold_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    next_state = last_b ? OWN_A : OWN_B;
                end else if (req_a) begin
                    next_state = OWN_A;
                end else if (req_b) begin
                    next_state = OWN_B;
                end
            end
            OWN_A: begin
                hold_inc = req_b;
                if (!req_a) begin
                    next_state = req_b ? OWN_B : IDLE;
                end else if (req_b && hold_term) begin
                    next_state = OWN_B;
                    forced     = 1'b1;
                end
            end
            OWN_B: begin
                hold_inc = req_a;
                if (!req_b) begin
                    next_state = req_a ? OWN_A : IDLE;
                end else if (req_a && hold_term) begin
                    next_state = OWN_A;
                    forced     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign hold_clr = (next_state != state);

    // last_b records who owned the path most recently; it breaks ties in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (hold_clr && state == OWN_A) begin
            last_b <= 1'b0;
        end else if (hold_clr && state == OWN_B) begin
            last_b <= 1'b1;
        end
    end

    assign gnt_a = (state == OWN_A);
    assign gnt_b = (state == OWN_B);
    assign sel   = gnt_b ? SEL_B : SEL_A;
    assign en    = gnt_a | gnt_b;

    // out_valid=1 means out_data holds a word captured during a granted cycle;
    // it lags the grant by one cycle and there is no backpressure from the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= 4'h0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_data  <= (sel == SEL_B) ? data_b : data_a;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_a <= 8'h00;
            grant_cnt_b <= 8'h00;
            forced_sw   <= 1'b0;
        end else begin
            forced_sw <= forced;
            if (next_state == OWN_A && state != OWN_A) begin
                grant_cnt_a <= grant_cnt_a + 8'h01;
            end
            if (next_state == OWN_B && state != OWN_B) begin
                grant_cnt_b <= grant_cnt_b + 8'h01;
            end
        end
    end
`else
    logic unused_forced;
    assign unused_forced = forced;
`endif

endmodule
